// File: rtl/nand_reduce_pkg.sv
// Shared types and elaboration-time helpers for the pipelined NAND-family reduction tree.
package nand_reduce_pkg;

    typedef enum logic [1:0] {OP_NAND, OP_AND, OP_NOR, OP_OR} op_e;

    function automatic logic is_or_class(op_e op);
        return (op == OP_NOR) || (op == OP_OR);
    endfunction

    function automatic logic is_inverting(op_e op);
        return (op == OP_NAND) || (op == OP_NOR);
    endfunction

    // Vectors alive after lvl pairwise levels; an odd leftover passes through.
    function automatic int nv_at(int n, int lvl);
        int v;
        v = n;
        for (int i = 0; i < lvl; i++) v = (v + 1) / 2;
        return v;
    endfunction

    // Bit offset of level lvl inside the flattened per-level vector bus.
    function automatic int vec_off(int n, int lvl, int lanes);
        int o;
        o = 0;
        for (int i = 0; i < lvl; i++) o += nv_at(n, i) * lanes;
        return o;
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One registered 2:1 level of the reduction tree: valid, op and partial vectors.
module reduce_stage
    import nand_reduce_pkg::*;
#(
    parameter int NV_IN = 2,
    parameter int LANES = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      adv,
    input  logic                                      in_valid,
    input  op_e                                       in_op,
    input  logic [NV_IN-1:0][LANES-1:0]               in_vec,
    output logic                                      valid,
    output op_e                                       op,
    output logic [((NV_IN+1)/2)-1:0][LANES-1:0]       vec
);

    localparam int NV_OUT = (NV_IN + 1) / 2;

    logic [NV_OUT-1:0][LANES-1:0] nxt;

    genvar j;
    for (j = 0; j < NV_OUT; j++) begin : g_pair
        if (2 * j + 1 < NV_IN) begin : g_two
            assign nxt[j] = is_or_class(in_op) ? (in_vec[2*j] | in_vec[2*j+1])
                                               : (in_vec[2*j] & in_vec[2*j+1]);
        end else begin : g_one
            assign nxt[j] = in_vec[2*j];
        end
    end

    // Payload only loads on a real transfer so a bubble leaves the regs quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            op    <= OP_NAND;
            vec   <= '0;
        end else if (adv) begin
            valid <= in_valid;
            if (in_valid) begin
                op  <= in_op;
                vec <= nxt;
            end
        end
    end

endmodule

// File: rtl/nand_reduce_pipe.sv
// Pipelined N-input NAND/AND/NOR/OR lane reduction with valid/ready on both ends.
module nand_reduce_pipe
    import nand_reduce_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int LANES  = 8,
    parameter int LEVELS = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic [NUM_IN*LANES-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_op,
    output logic [LANES-1:0]          out_data,
    input  logic                      VPB,
    input  logic                      VPWR,
    input  logic                      VGND,
    input  logic                      VNB
);

    localparam int TOT  = vec_off(NUM_IN, LEVELS + 1, LANES);
    localparam int LAST = vec_off(NUM_IN, LEVELS, LANES);

    logic [TOT-1:0]     vec_bus;
    logic [LEVELS:0]    vld_pipe;
    logic [LEVELS+1:1]  adv;
    op_e                op_pipe [LEVELS:0];
    logic [LANES-1:0]   res;

    // Power/bias pins exist only for netlist compatibility.
    wire unused_power = &{1'b0, VPB, VPWR, VGND, VNB};

    assign vec_bus[NUM_IN*LANES-1:0] = in_data;
    assign vld_pipe[0]               = in_valid;
    assign op_pipe[0]                = op_e'(in_op);

    // A stage may load when it is empty or its successor is loading too.
    always_comb begin
        adv[LEVELS+1] = out_ready;
        for (int s = LEVELS; s >= 1; s--) adv[s] = !vld_pipe[s] || adv[s+1];
    end

    assign in_ready = adv[1];

    genvar s;
    for (s = 1; s <= LEVELS; s++) begin : g_lvl
        reduce_stage #(
            .NV_IN (nv_at(NUM_IN, s - 1)),
            .LANES (LANES)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv[s]),
            .in_valid (vld_pipe[s-1]),
            .in_op    (op_pipe[s-1]),
            .in_vec   (vec_bus[vec_off(NUM_IN, s - 1, LANES) +: nv_at(NUM_IN, s - 1) * LANES]),
            .valid    (vld_pipe[s]),
            .op       (op_pipe[s]),
            .vec      (vec_bus[vec_off(NUM_IN, s, LANES) +: nv_at(NUM_IN, s) * LANES])
        );
    end

    assign res       = vec_bus[LAST +: LANES];
    assign out_valid = vld_pipe[LEVELS];
    assign out_op    = op_pipe[LEVELS];
    // Gated by valid so an idle or reset pipe shows zero rather than inverted zeros.
    assign out_data  = !vld_pipe[LEVELS]            ? '0   :
                       is_inverting(op_pipe[LEVELS]) ? ~res : res;

endmodule
